uart_rx_axis: RTL
=================

Name: uart_rx_axis

Overview:
- UART receiver: the serial-line consumer of the UART transmitter's data_tx_o output.
- Oversamples rx_i, validates the start bit, samples each data bit at mid-bit, checks the stop bit, and presents each received word on an AXI-Stream-style master interface.
- Downstream is an RX FIFO or register interface.
- Frame format matches the transmitter: 1 start bit (0), WIDTH data bits LSB first, 1 stop bit (1), no parity.

Parameters:
- WIDTH, 8: data bits per frame.
- CLK_FREQ, 100_000_000: clk_i frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- OVERSAMPLE, 16: ticks per bit. Must be even and >= 4.
- DIV, CLK_FREQ/(BAUD_RATE*OVERSAMPLE): clk_i cycles per tick (derived localparam). Must be >= 1; elaboration error otherwise.

Ports:
- clk_i, input, 1: single system clock; all logic on its rising edge.
- reset_i, input, 1: synchronous, active-low reset.
- rx_i, input, 1: asynchronous serial line; idles high.
- tdata_o, output, WIDTH: received word.
- tvalid_o, output, 1: tdata_o holds an undelivered word.
- tready_i, input, 1: downstream accepts the word.
- busy_o, output, 1: high while a frame is being received.
- frame_err_o, output, 1: one-cycle pulse when the stop bit is sampled as 0.
- overrun_o, output, 1: one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset (reset_i=0 at a clk_i edge):
  - tdata_o=0, tvalid_o=0, busy_o=0, frame_err_o=0, overrun_o=0.
  - FSM=IDLE; all counters 0; synchroniser flops and edge-history flop = 1.
  - Reset mid-frame aborts the frame silently.
- Synchroniser: 2-flop synchroniser on rx_i gives rx_s. rx_q is rx_s delayed one cycle, used for edge detection.
- Tick generator:
  - Free-running counter 0..DIV-1 (width $clog2(DIV), minimum 1 bit).
  - tick=1 for one cycle when count==DIV-1, then the counter wraps to 0.
  - Runs in every state; no clock gating, no derived clocks.
- sample_cnt: width $clog2(OVERSAMPLE); increments on tick and is cleared on each transition below.
- bit_cnt: width $clog2(WIDTH+1).
- FSM transitions:
  - IDLE: on a falling edge (rx_q=1 and rx_s=0), go to START with sample_cnt=0. A level-low line with no edge does not start a frame.
  - START: on the tick where sample_cnt==OVERSAMPLE/2-1:
    - rx_s=0: go to DATA, clear sample_cnt and bit_cnt.
    - rx_s=1: glitch; return to IDLE with no output.
  - DATA: on the tick where sample_cnt==OVERSAMPLE-1:
    - Shift rx_s in at the MSB of shift_reg (LSB-first assembly); bit_cnt++; sample_cnt=0.
    - When bit_cnt reaches WIDTH, go to STOP.
  - STOP: on the tick where sample_cnt==OVERSAMPLE-1, go to IDLE (mid stop bit, which allows back-to-back frames).
    - rx_s=1: deliver shift_reg (see output register).
    - rx_s=0: frame_err_o pulses for the next cycle; word discarded.
- busy_o = (state != IDLE), registered with the state.
- Output register (single entry):
  - On delivery with tvalid_o=0, or with tvalid_o=1 and tready_i=1 in the same cycle: load tdata_o and set tvalid_o=1 the next cycle. No overrun in either case.
  - On delivery with tvalid_o=1 and tready_i=0: the new word is dropped, tdata_o is unchanged, and overrun_o pulses for the next cycle.
  - tvalid_o=1 and tready_i=1 with no delivery: tvalid_o clears the next cycle.
  - tdata_o is stable while tvalid_o=1 and tready_i=0.
  - tvalid_o never depends combinationally on tready_i.
- Latency: tvalid_o rises 1 clk_i after the stop-bit sample tick.
- Sampling tolerance: the start edge is seen up to 2 clk_i cycles (synchroniser) plus up to 1 tick late. This is acceptable for OVERSAMPLE >= 4.

Decomposition:
- Shared package uart_pkg holds:
  - state typedef uart_state_t: IDLE, START, DATA, STOP. The transmitter uses the same encoding.
  - Frame constants: START_BIT=0, STOP_BIT=1.
  - Function calc_div(clk, baud, os).
- One sub-module, uart_baud_tick: tick-enable generator (parameter DIV; ports clk_i, reset_i, tick_o). It is also intended for reuse by the transmitter in place of a derived clock.

Test Plan:
- Sim params CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, giving DIV=10 and a 160-cycle bit.
- Send 0xA5 with tready_i=1 -> tvalid_o high exactly 1 cycle with tdata_o=0xA5; frame_err_o=0, overrun_o=0; busy_o low after the stop sample.
- Drive rx_i low for 40 cycles (shorter than a half bit), then high -> return to IDLE; no tvalid_o, no frame_err_o.
- Send 0x3C with the stop bit forced 0, then release the line high -> single frame_err_o pulse, tvalid_o stays 0; next frame 0x5A is received correctly.
- tready_i=0; send 0x11 then 0x22 -> tvalid_o=1 with tdata_o=0x11 held; one overrun_o pulse on the second frame; raising tready_i consumes 0x11 and tvalid_o falls; 0x22 is never presented.
- Back-to-back 0x00 then 0xFF, no idle gap, tready_i=1 -> both delivered in order; no errors.
- reset_i=0 for 3 cycles during data bit 4 -> all outputs at reset values; the following 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame bit levels and the
// baud divider calculation used by both receiver and transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // clk cycles per oversampling tick
   function automatic int calc_div(input int clk, input int baud, input int os);
      return clk / (baud * os);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running tick-enable generator: tick_o is high for one clk_i cycle
// out of every DIV, so downstream logic stays on the single system clock.
module uart_baud_tick #(
   parameter int DIV = 16
) (
   input  logic clk_i,
   input  logic reset_i,
   output logic tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      // NOTE: default first so every path assigns count_d; otherwise a latch is inferred.
      count_d = count_q + CW'(1);
      if (count_q == LAST) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_o = (count_q == LAST);

endmodule

// File: rtl/uart_rx_axis.sv
// Oversampling UART receiver: synchronises rx_i, validates the start bit,
// samples data mid-bit and presents each word on a single-entry stream output.
module uart_rx_axis
   import uart_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             rx_i,
   output logic [WIDTH-1:0] tdata_o,
   output logic             tvalid_o,
   input  logic             tready_i,
   output logic             busy_o,
   output logic             frame_err_o,
   output logic             overrun_o
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int SCW = $clog2(OVERSAMPLE);
   localparam int BCW = $clog2(WIDTH + 1);

   localparam logic [SCW-1:0] HALF_M1  = SCW'(OVERSAMPLE / 2 - 1);
   localparam logic [SCW-1:0] FULL_M1  = SCW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   if (DIV < 1) begin : g_div_chk
      $error("uart_rx_axis: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE (DIV < 1)");
   end
   if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
      $error("uart_rx_axis: OVERSAMPLE must be even and >= 4");
   end

   logic tick;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .tick_o  (tick)
   );

   logic sync1_q, rx_s_q, rx_q;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
         rx_q    <= 1'b1;
      end else begin
         sync1_q <= rx_i;
         rx_s_q  <= sync1_q;
         rx_q    <= rx_s_q;
      end
   end

   uart_state_t      state_q, state_d;
   logic [SCW-1:0]   sample_cnt_q, sample_cnt_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH:0]   shift_in;
   logic             deliver, stop_err;

   assign shift_in = {rx_s_q, shift_q};

   always_comb begin
      state_d      = state_q;
      sample_cnt_d = tick ? sample_cnt_q + SCW'(1) : sample_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      deliver      = 1'b0;
      stop_err     = 1'b0;
      unique case (state_q)
         IDLE: begin
            sample_cnt_d = '0;
            if (rx_q && !rx_s_q) begin
               state_d = START;
            end
         end
         START: begin
            if (tick && sample_cnt_q == HALF_M1) begin
               sample_cnt_d = '0;
               bit_cnt_d    = '0;
               state_d      = (rx_s_q == START_BIT) ? DATA : IDLE;
            end
         end
         DATA: begin
            if (tick && sample_cnt_q == FULL_M1) begin
               // LSB arrives first, so shifting right leaves bit 0 at the bottom
               shift_d      = shift_in[WIDTH:1];
               bit_cnt_d    = bit_cnt_q + BCW'(1);
               sample_cnt_d = '0;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (tick && sample_cnt_q == FULL_M1) begin
               sample_cnt_d = '0;
               state_d      = IDLE;
               deliver      = (rx_s_q == STOP_BIT);
               stop_err     = (rx_s_q != STOP_BIT);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q      <= IDLE;
         sample_cnt_q <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         busy_o       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         busy_o       <= (state_d != IDLE);
      end
   end

   // Single-entry output: a word arriving while the slot is full and not
   // being drained is dropped so tdata_o stays stable under backpressure.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         tdata_o     <= '0;
         tvalid_o    <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         frame_err_o <= stop_err;
         overrun_o   <= 1'b0;
         if (deliver) begin
            if (!tvalid_o || tready_i) begin
               tdata_o  <= shift_q;
               tvalid_o <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (tvalid_o && tready_i) begin
            tvalid_o <= 1'b0;
         end
      end
   end

endmodule
